// File: rtl/modport_fifo_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO itself (slave).
interface modport_fifo_if #(
  parameter int unsigned FIFO_WIDTH = 32
);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  empty;
  logic                  full;
  logic [FIFO_WIDTH-1:0] data_out;

  // Master drives requests and write data; it observes status and read data.
  modport master (
    output wr_en,
    output data_in,
    output rd_en,
    input  empty,
    input  full,
    input  data_out
  );

  // Slave is the FIFO: it consumes requests and produces status and read data.
  modport slave (
    input  wr_en,
    input  data_in,
    input  rd_en,
    output empty,
    output full,
    output data_out
  );

endinterface

// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with registered flags and registered read data.
// The read word is available after the edge that accepts rd_en; there is no fall-through.
module modport_fifo #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input logic           clk,
  input logic           rstN,
  modport_fifo_if.slave bus
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]        count_q, count_d;
  logic                  wr_acc, rd_acc;

  // Acceptance decoded from pre-edge flags; a write into a full FIFO is only
  // taken when a read frees a slot on the same edge.
  always_comb begin
    wr_acc  = bus.wr_en & (~bus.full | bus.rd_en);
    rd_acc  = bus.rd_en & ~bus.empty;
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are not reset, the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  // Pointers, occupancy, flags and read data register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      bus.empty    <= 1'b1;
      bus.full     <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        bus.data_out <= mem[rd_ptr_q];
      end
      count_q   <= count_d;
      bus.empty <= (count_d == '0);
      bus.full  <= (count_d == DepthCnt);
    end
  end

  // Request strobes must be known whenever the FIFO is out of reset.
  assert property (@(posedge clk) disable iff (!rstN) !$isunknown({bus.wr_en, bus.rd_en}))
    else $error("modport_fifo: X on wr_en/rd_en");

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: reset, fill/drain, overflow, underflow,
// simultaneous read/write across wrap and when full, reset mid-stream.
module tb_modport_fifo;

  logic clk;
  logic rstN;
  int   total;
  int   bad;

  modport_fifo_if #(.FIFO_WIDTH(32)) bus_if ();

  modport_fifo #(
    .FIFO_WIDTH(32),
    .FIFO_DEPTH(32)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, let the edge take them, then sample 1 ns later.
  task automatic step(input logic wr, input logic [31:0] din, input logic rd);
    bus_if.wr_en   = wr;
    bus_if.data_in = din;
    bus_if.rd_en   = rd;
    @(posedge clk);
    #1;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.data_in = '0;
    rstN           = 1'b0;
    #12;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("reset_empty", {31'd0, bus_if.empty}, 32'd1);
    check("reset_full", {31'd0, bus_if.full}, 32'd0);
    check("reset_dout", bus_if.data_out, 32'd0);

    // Fill with 0x00..0x1F.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 0) check("fill_empty_after_first", {31'd0, bus_if.empty}, 32'd0);
      if (i == 30) check("fill_full_after_31", {31'd0, bus_if.full}, 32'd0);
    end
    check("fill_full_after_32", {31'd0, bus_if.full}, 32'd1);
    check("fill_dout_untouched", bus_if.data_out, 32'd0);

    // Overflow attempt is dropped.
    step(1'b1, 32'hDEADBEEF, 1'b0);
    check("ovf_full", {31'd0, bus_if.full}, 32'd1);
    check("ovf_dout", bus_if.data_out, 32'd0);

    // Drain: original 32 words in order, no 0xDEADBEEF.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 32'd0, 1'b1);
      check($sformatf("drain_%0d", i), bus_if.data_out, 32'(i));
      if (i == 0) check("drain_full_cleared", {31'd0, bus_if.full}, 32'd0);
      if (i == 30) check("drain_not_empty_31", {31'd0, bus_if.empty}, 32'd0);
    end
    check("drain_empty", {31'd0, bus_if.empty}, 32'd1);

    // Underflow: reads while empty are ignored.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b1);
      check($sformatf("udf_dout_%0d", i), bus_if.data_out, 32'h1F);
      check($sformatf("udf_empty_%0d", i), {31'd0, bus_if.empty}, 32'd1);
    end

    // Write and read together while empty: only the write is taken.
    step(1'b1, 32'h100, 1'b1);
    check("empty_wr_rd_dout", bus_if.data_out, 32'h1F);
    check("empty_wr_rd_empty", {31'd0, bus_if.empty}, 32'd0);
    for (int i = 1; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);

    // Five stored; 40 simultaneous cycles cross the pointer wrap.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 32'h105 + 32'(k), 1'b1);
      check($sformatf("sim_dout_%0d", k), bus_if.data_out, 32'h100 + 32'(k));
    end
    check("sim_empty", {31'd0, bus_if.empty}, 32'd0);
    check("sim_full", {31'd0, bus_if.full}, 32'd0);

    // Stored now: 0x128..0x12C. Top up with 27 words to reach full.
    for (int j = 0; j < 27; j++) begin
      step(1'b1, 32'h200 + 32'(j), 1'b0);
      if (j == 25) check("topup_full_at_31", {31'd0, bus_if.full}, 32'd0);
    end
    check("topup_full", {31'd0, bus_if.full}, 32'd1);

    // Simultaneous while full: full holds, oldest words come out.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'h300 + 32'(k), 1'b1);
      check($sformatf("fullsim_dout_%0d", k), bus_if.data_out,
            (k < 5) ? 32'h128 + 32'(k) : 32'h200 + 32'(k - 5));
      check($sformatf("fullsim_full_%0d", k), {31'd0, bus_if.full}, 32'd1);
    end

    // Asynchronous reset mid-cycle while full with nonzero data_out.
    #2;
    rstN = 1'b0;
    #1;
    check("areset_empty", {31'd0, bus_if.empty}, 32'd1);
    check("areset_full", {31'd0, bus_if.full}, 32'd0);
    check("areset_dout", bus_if.data_out, 32'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream after 10 writes; nothing remains to read.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
    check("stream_not_empty", {31'd0, bus_if.empty}, 32'd0);
    #2;
    rstN = 1'b0;
    #1;
    check("stream_rst_empty", {31'd0, bus_if.empty}, 32'd1);
    check("stream_rst_dout", bus_if.data_out, 32'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 32'd0, 1'b1);
    check("post_rst_read_dout", bus_if.data_out, 32'd0);
    check("post_rst_read_empty", {31'd0, bus_if.empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
